// File: rtl/axi_lite_mem_master_if.sv
// axi_lite_channel: AXI-lite channel bundle (AW, W, B, AR, R) between one master and one slave.
// Ports: clk, rstn (active-low reset of the attached slave side).
// Modports: master drives AW/W/AR payload and valids plus B/R readies; slave is the mirror.
interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input logic clk,
  input logic rstn
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
  modport slave (
    input  clk, rstn, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_mem_master.sv
// axi_lite_mem_master: bridges a valid/ready word request port to an AXI-lite master, one transaction outstanding.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_we/req_addr/req_wdata request port;
// resp_valid/resp_ready/resp_rdata/resp_err completion port; master AXI-lite master port.
module axi_lite_mem_master #(
  parameter int DATA_WIDTH      = 64,
  parameter int WORD_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DATA_WIDTH/8-1:0]    req_we,
  input  logic [WORD_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DATA_WIDTH-1:0]      resp_rdata,
  output logic                       resp_err,
  axi_lite_channel.master            master
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(SW);
  localparam int AW  = master.ADDR_WIDTH;
  localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, WAIT_B = 3'd2, RD = 3'd3, WAIT_R = 3'd4, RESP = 3'd5;
  if (DATA_WIDTH != master.DATA_WIDTH) begin : g_dw_chk
    $fatal(1, "axi_lite_mem_master: DATA_WIDTH differs from master.DATA_WIDTH");
  end
  if (WORD_ADDR_WIDTH + OFF > AW) begin : g_aw_chk
    $fatal(1, "axi_lite_mem_master: word address does not fit master.ADDR_WIDTH");
  end
  logic [2:0]            state_q, state_d;
  logic                  aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, ar_valid_q, ar_valid_d;
  logic                  b_ready_q, b_ready_d, r_ready_q, r_ready_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic                  aw_hs, w_hs;
  assign aw_hs = aw_valid_q && master.aw_ready;
  assign w_hs  = w_valid_q && master.w_ready;
  always_comb begin
    state_d      = state_q;
    aw_valid_d   = aw_valid_q;
    w_valid_d    = w_valid_q;
    ar_valid_d   = ar_valid_q;
    b_ready_d    = b_ready_q;
    r_ready_d    = r_ready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    strb_d       = strb_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = AW'(req_addr) << OFF;
        wdata_d = req_wdata;
        strb_d  = req_we;
        if (|req_we) begin
          state_d    = WR;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end else begin
          state_d    = RD;
          ar_valid_d = 1'b1;
        end
      end
      WR: begin
        // AW and W retire independently; B is only accepted once both are gone
        aw_valid_d = aw_valid_q && !aw_hs;
        w_valid_d  = w_valid_q && !w_hs;
        aw_done_d  = aw_done_q || aw_hs;
        w_done_d   = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = WAIT_B;
          b_ready_d = 1'b1;
        end
      end
      WAIT_B: if (master.b_valid) begin
        state_d      = RESP;
        b_ready_d    = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = master.b_resp != 2'b00;
        rdata_d      = '0;
      end
      RD: if (master.ar_ready) begin
        state_d    = WAIT_R;
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b1;
      end
      WAIT_R: if (master.r_valid) begin
        state_d      = RESP;
        r_ready_d    = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = master.r_resp != 2'b00;
        rdata_d      = master.r_data;
      end
      RESP: if (resp_ready) begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      b_ready_q    <= 1'b0;
      r_ready_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
    end else begin
      state_q      <= state_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      ar_valid_q   <= ar_valid_d;
      b_ready_q    <= b_ready_d;
      r_ready_q    <= r_ready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
    end
  end
  assign req_ready       = state_q == IDLE;
  assign resp_valid      = resp_valid_q;
  assign resp_err        = resp_err_q;
  assign resp_rdata      = rdata_q;
  assign master.aw_valid = aw_valid_q;
  assign master.aw_addr  = addr_q;
  assign master.w_valid  = w_valid_q;
  assign master.w_data   = wdata_q;
  assign master.w_strb   = strb_q;
  assign master.b_ready  = b_ready_q;
  assign master.ar_valid = ar_valid_q;
  assign master.ar_addr  = addr_q;
  assign master.r_ready  = r_ready_q;
endmodule

// File: tb/tb_axi_lite_mem_master.sv
// tb_axi_lite_mem_master: directed and soak checks of the AXI-lite bridge against a BRAM slave model with a response scoreboard.
module tb_axi_lite_mem_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_we = '0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  int compared = 0, mismatched = 0;
  logic [64:0] exp_q[$];
  logic [63:0] ref_mem [0:255];
  logic [63:0] mem [0:255];
  int fx[5], rd[5], cnt[5];
  bit rand_mode = 1'b0, rr_force = 1'b1, rr_val = 1'b1, rr_rand = 1'b1;
  logic [1:0] code = 2'b00;
  logic [4:0] hs, act, go;
  logic aw_seen, w_seen, ar_seen;
  logic [7:0] aw_a, ar_a, w_s;
  logic [63:0] w_d;

  always #5 clk = ~clk;

  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) axi (.clk(clk), .rstn(~rst));

  axi_lite_mem_master #(.DATA_WIDTH(64), .WORD_ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .master(axi.master)
  );

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
    for (int b = 0; b < 8; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
    return old;
  endfunction

  // BRAM slave: each channel waits a programmable (or random) number of cycles before responding
  assign hs  = {axi.r_valid && axi.r_ready, axi.ar_valid && axi.ar_ready, axi.b_valid && axi.b_ready,
                axi.w_valid && axi.w_ready, axi.aw_valid && axi.aw_ready};
  assign act = {ar_seen, axi.ar_valid, aw_seen && w_seen, axi.w_valid, axi.aw_valid};
  always_comb for (int i = 0; i < 5; i++) go[i] = cnt[i] >= (rand_mode ? rd[i] : fx[i]);
  assign axi.aw_ready = axi.aw_valid && go[0];
  assign axi.w_ready  = axi.w_valid && go[1];
  assign axi.b_valid  = aw_seen && w_seen && go[2];
  assign axi.b_resp   = code;
  assign axi.ar_ready = axi.ar_valid && go[3];
  assign axi.r_valid  = ar_seen && go[4];
  assign axi.r_data   = mem[ar_a];
  assign axi.r_resp   = code;
  assign resp_ready   = rr_force ? rr_val : rr_rand;

  always @(posedge clk) begin
    rr_rand <= $urandom_range(0, 3) != 0;
    for (int i = 0; i < 5; i++)
      if (rst) cnt[i] <= 0;
      else if (hs[i]) begin cnt[i] <= 0; rd[i] <= int'($urandom_range(0, 3)); end
      else if (act[i]) cnt[i] <= cnt[i] + 1;
    if (rst) begin
      aw_seen <= 1'b0; w_seen <= 1'b0; ar_seen <= 1'b0;
    end else begin
      if (hs[0]) begin aw_seen <= 1'b1; aw_a <= axi.aw_addr[10:3]; end
      if (hs[1]) begin w_seen <= 1'b1; w_d <= axi.w_data; w_s <= axi.w_strb; end
      if (hs[2]) begin
        aw_seen <= 1'b0; w_seen <= 1'b0;
        if (code == 2'b00) mem[aw_a] <= merge(mem[aw_a], w_d, w_s);
      end
      if (hs[3]) begin ar_seen <= 1'b1; ar_a <= axi.ar_addr[10:3]; end
      if (hs[4]) ar_seen <= 1'b0;
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic summary_fatal(input string n);
    compared++; mismatched++;
    $display("FAIL %s: timeout at %0t", n, $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "bench stopped");
  endtask

  // Scoreboard monitor plus AXI/response stability checks, sampled 1ns after the falling edge
  logic p_rst = 1'b1, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr, p_re;
  logic [31:0] p_awa, p_ara;
  logic [63:0] p_wd, p_rd;
  logic [7:0]  p_ws;
  always @(negedge clk) begin
    #1;
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'd0);
      else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e[63:0]);
        chk("resp_err", 64'(resp_err), 64'(e[64]));
      end
    end
    if (!p_rst && !rst) begin
      if (p_awv && !p_awr) begin chk("aw_hold", 64'(axi.aw_valid), 64'd1); chk("aw_addr_stable", 64'(axi.aw_addr), 64'(p_awa)); end
      if (p_wv && !p_wr) begin
        chk("w_hold", 64'(axi.w_valid), 64'd1); chk("w_data_stable", axi.w_data, p_wd); chk("w_strb_stable", 64'(axi.w_strb), 64'(p_ws));
      end
      if (p_arv && !p_arr) begin chk("ar_hold", 64'(axi.ar_valid), 64'd1); chk("ar_addr_stable", 64'(axi.ar_addr), 64'(p_ara)); end
      if (p_rv && !p_rr) begin
        chk("resp_hold", 64'(resp_valid), 64'd1); chk("resp_rdata_stable", resp_rdata, p_rd); chk("resp_err_stable", 64'(resp_err), 64'(p_re));
      end
    end
    p_rst = rst;
    p_awv = axi.aw_valid; p_awr = axi.aw_ready; p_awa = axi.aw_addr;
    p_wv = axi.w_valid; p_wr = axi.w_ready; p_wd = axi.w_data; p_ws = axi.w_strb;
    p_arv = axi.ar_valid; p_arr = axi.ar_ready; p_ara = axi.ar_addr;
    p_rv = resp_valid; p_rr = resp_ready; p_rd = resp_rdata; p_re = resp_err;
  end

  // Called at a falling edge; returns at the falling edge one cycle after the request handshake
  task automatic start(input logic [7:0] we, input logic [15:0] a, input logic [63:0] d, input bit push);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; !req_ready; i++) begin
      if (i >= 300) summary_fatal("req_ready_wait");
      @(negedge clk);
    end
    if (push) begin
      exp_q.push_back({code != 2'b00, we != 0 ? 64'h0 : ref_mem[a[7:0]]});
      if (we != 0 && code == 2'b00) ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], d, we);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; !(exp_q.size() == 0 && req_ready); i++) begin
      if (i >= 300) summary_fatal("idle_wait");
      @(negedge clk);
    end
  endtask

  task automatic wait_resp();
    for (int i = 0; !resp_valid; i++) begin
      if (i >= 60) summary_fatal("resp_valid_wait");
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000 summary_fatal("global");
  end

  initial begin
    logic [7:0] we;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[16] = 64'hDEADBEEF_CAFEF00D; ref_mem[16] = 64'hDEADBEEF_CAFEF00D;
    for (int i = 0; i < 5; i++) fx[i] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_valids", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, resp_valid}), 64'd0);
    chk("reset_resp", {resp_rdata[62:0], resp_err}, 64'd0);

    // zero-wait read
    start(8'h00, 16'h0010, 64'h0, 1'b1);
    chk("rd_ar_valid_c1", 64'(axi.ar_valid), 64'd1);
    chk("rd_ar_addr_c1", 64'(axi.ar_addr), 64'h80);
    @(negedge clk);
    chk("rd_r_ready_c2", 64'(axi.r_ready), 64'd1);
    chk("rd_ar_drop_c2", 64'(axi.ar_valid), 64'd0);
    @(negedge clk);
    chk("rd_resp_valid_c3", 64'(resp_valid), 64'd1);
    chk("rd_data_c3", resp_rdata, 64'hDEADBEEF_CAFEF00D);
    wait_idle();

    // write with W accepted four cycles after AW
    fx[1] = 4;
    start(8'h0F, 16'h0003, 64'h1122334455667788, 1'b1);
    chk("wr_aw_valid_c1", 64'(axi.aw_valid), 64'd1);
    chk("wr_aw_addr_c1", 64'(axi.aw_addr), 64'h18);
    chk("wr_w_data_c1", axi.w_data, 64'h1122334455667788);
    @(negedge clk);
    chk("wr_aw_drop_c2", 64'(axi.aw_valid), 64'd0);
    for (int c = 2; c <= 5; c++) begin
      chk("wr_w_valid_held", 64'(axi.w_valid), 64'd1);
      chk("wr_w_strb_held", 64'(axi.w_strb), 64'h0F);
      chk("wr_b_ready_low", 64'(axi.b_ready), 64'd0);
      @(negedge clk);
    end
    chk("wr_w_drop_c6", 64'(axi.w_valid), 64'd0);
    chk("wr_b_ready_c6", 64'(axi.b_ready), 64'd1);
    @(negedge clk);
    chk("wr_resp_valid_c7", 64'(resp_valid), 64'd1);
    chk("wr_resp_rdata_zero", resp_rdata, 64'h0);
    wait_idle();
    fx[1] = 0;
    start(8'h00, 16'h0003, 64'h0, 1'b1);
    wait_resp();
    chk("wr_readback", resp_rdata, 64'h00000000_55667788);
    wait_idle();

    // error responses
    code = 2'b10;
    start(8'h00, 16'h0010, 64'h0, 1'b1);
    wait_resp();
    chk("slverr_read", 64'(resp_err), 64'd1);
    wait_idle();
    code = 2'b11;
    start(8'hFF, 16'h0005, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_resp();
    chk("decerr_write", 64'(resp_err), 64'd1);
    wait_idle();
    code = 2'b00;

    // response backpressure
    rr_val = 1'b0;
    start(8'h00, 16'h0010, 64'h0, 1'b1);
    wait_resp();
    for (int c = 0; c < 6; c++) begin
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_resp_rdata", resp_rdata, 64'hDEADBEEF_CAFEF00D);
      chk("bp_req_ready_low", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rr_val = 1'b1;
    chk("bp_req_ready_same", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("bp_req_ready_next", 64'(req_ready), 64'd1);
    chk("bp_resp_valid_drop", 64'(resp_valid), 64'd0);
    wait_idle();

    // reset while waiting on R
    fx[4] = 20;
    start(8'h00, 16'h0010, 64'h0, 1'b0);
    for (int i = 0; !axi.r_ready; i++) begin
      if (i >= 10) summary_fatal("r_ready_wait");
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valids", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, resp_valid}), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    fx[4] = 0;
    start(8'h00, 16'h0003, 64'h0, 1'b1);
    wait_resp();
    chk("rst_new_read", resp_rdata, 64'h00000000_55667788);
    wait_idle();

    // random soak
    rand_mode = 1'b1;
    rr_force = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      we = $urandom_range(0, 1) != 0 ? 8'($urandom_range(1, 255)) : 8'h00;
      start(we, 16'($urandom_range(0, 15)), {$urandom, $urandom}, 1'b1);
    end
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
